// File: rtl/vga_frame_writer.sv
// rtl/vga_frame_writer.sv - port-B write engine for the VGA frame RAM and position tables
// Optional XOR pixel op is built only when VGA_WR_XOR_EN is defined.
module vga_frame_writer #(
    parameter int SCR_W   = 480,
    parameter int SCR_H   = 480,
    parameter int RAM_LAT = 1
) (
    input  logic              clk_50,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [8:0]        cmd_x,
    input  logic [8:0]        cmd_y,
    input  logic [9:0]        cmd_idx,
    input  logic [25:0]       cmd_data,
    output logic              done,
    output logic              err,
    output logic              ram_480_480_write,
    output logic [8:0]        ram_480_480_address_rw,
    output logic [SCR_W-1:0]  ram_480_480_din,
    input  logic [SCR_W-1:0]  ram_480_480_dout_rw,
    output logic              ram_picture_position_write,
    output logic [9:0]        ram_picture_position_address_rw,
    output logic [25:0]       ram_picture_position_din,
    output logic              ram_word_position_write,
    output logic [9:0]        ram_word_position_address_b,
    output logic [25:0]       ram_word_position_din
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD   = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_WR   = 3'd3;
    localparam logic [2:0] S_CLS  = 3'd4;
    localparam logic [2:0] S_POS  = 3'd5;
    localparam logic [2:0] S_FIN  = 3'd6;

    localparam logic [2:0] OP_SET  = 3'b000;
    localparam logic [2:0] OP_CLR  = 3'b001;
    localparam logic [2:0] OP_XOR  = 3'b010;
    localparam logic [2:0] OP_CLS  = 3'b011;
    localparam logic [2:0] OP_PIC  = 3'b100;
    localparam logic [2:0] OP_WORD = 3'b101;

    localparam logic [8:0] X_LIM    = 9'(SCR_W);
    localparam logic [8:0] Y_LIM    = 9'(SCR_H);
    localparam logic [8:0] ROW_LAST = 9'(SCR_H - 1);
    localparam int         LW       = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;
    localparam logic [LW-1:0] LAT_LAST = LW'(RAM_LAT - 1);

    logic [2:0]       state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [8:0]       x_q, x_d;
    logic [8:0]       row_q, row_d;
    logic [LW-1:0]    lat_q, lat_d;
    logic             cmd_ready_q, cmd_ready_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             frame_we_q, frame_we_d;
    logic [8:0]       frame_addr_q, frame_addr_d;
    logic [SCR_W-1:0] frame_din_q, frame_din_d;
    logic             pic_we_q, pic_we_d;
    logic [9:0]       pic_addr_q, pic_addr_d;
    logic [25:0]      pic_din_q, pic_din_d;
    logic             word_we_q, word_we_d;
    logic [9:0]       word_addr_q, word_addr_d;
    logic [25:0]      word_din_q, word_din_d;

    logic             is_pixel_op;
    logic [SCR_W-1:0] pix_mask;
    logic [SCR_W-1:0] rmw_row;

    always_comb begin
        is_pixel_op = (cmd_op == OP_SET) || (cmd_op == OP_CLR);
`ifdef VGA_WR_XOR_EN
        if (cmd_op == OP_XOR) begin
            is_pixel_op = 1'b1;
        end
`endif
    end

    always_comb begin
        pix_mask = {{(SCR_W-1){1'b0}}, 1'b1} << x_q;
        rmw_row  = ram_480_480_dout_rw;
        case (op_q)
            OP_SET:  rmw_row = ram_480_480_dout_rw | pix_mask;
            OP_CLR:  rmw_row = ram_480_480_dout_rw & ~pix_mask;
`ifdef VGA_WR_XOR_EN
            OP_XOR:  rmw_row = ram_480_480_dout_rw ^ pix_mask;
`endif
            default: rmw_row = ram_480_480_dout_rw;
        endcase
    end

    // Registered outputs are computed for the state being entered, so each
    // state's port-B activity is visible while the FSM sits in that state.
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        x_d          = x_q;
        row_d        = row_q;
        lat_d        = lat_q;
        cmd_ready_d  = 1'b0;
        done_d       = 1'b0;
        err_d        = 1'b0;
        frame_we_d   = 1'b0;
        frame_addr_d = frame_addr_q;
        frame_din_d  = frame_din_q;
        pic_we_d     = 1'b0;
        pic_addr_d   = pic_addr_q;
        pic_din_d    = pic_din_q;
        word_we_d    = 1'b0;
        word_addr_d  = word_addr_q;
        word_din_d   = word_din_q;

        case (state_q)
            S_IDLE: begin
                cmd_ready_d = 1'b1;
                if (cmd_valid) begin
                    cmd_ready_d = 1'b0;
                    op_d        = cmd_op;
                    x_d         = cmd_x;
                    if (is_pixel_op) begin
                        if ((cmd_x < X_LIM) && (cmd_y < Y_LIM)) begin
                            state_d      = S_RD;
                            frame_addr_d = cmd_y;
                        end else begin
                            state_d = S_FIN;
                            done_d  = 1'b1;
                            err_d   = 1'b1;
                        end
                    end else if (cmd_op == OP_CLS) begin
                        state_d = S_CLS;
                        row_d   = 9'd0;
                    end else if (cmd_op == OP_PIC) begin
                        state_d    = S_POS;
                        pic_we_d   = 1'b1;
                        pic_addr_d = cmd_idx;
                        pic_din_d  = cmd_data;
                    end else if (cmd_op == OP_WORD) begin
                        state_d     = S_POS;
                        word_we_d   = 1'b1;
                        word_addr_d = cmd_idx;
                        word_din_d  = cmd_data;
                    end else begin
                        state_d = S_FIN;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end
                end
            end
            S_RD: begin
                state_d = S_WAIT;
                lat_d   = '0;
            end
            S_WAIT: begin
                if (lat_q == LAT_LAST) begin
                    state_d     = S_WR;
                    frame_we_d  = 1'b1;
                    frame_din_d = rmw_row;
                end else begin
                    lat_d = lat_q + LW'(1);
                end
            end
            S_WR: begin
                state_d = S_FIN;
                done_d  = 1'b1;
            end
            S_CLS: begin
                // Leave only once the last row's write has been presented.
                if (frame_we_q && (frame_addr_q == ROW_LAST)) begin
                    state_d = S_FIN;
                    done_d  = 1'b1;
                end else begin
                    frame_we_d   = 1'b1;
                    frame_addr_d = row_q;
                    frame_din_d  = '0;
                    if (row_q != ROW_LAST) begin
                        row_d = row_q + 9'd1;
                    end
                end
            end
            S_POS: begin
                state_d = S_FIN;
                done_d  = 1'b1;
            end
            S_FIN: begin
                state_d     = S_IDLE;
                cmd_ready_d = 1'b1;
            end
            default: begin
                state_d     = S_IDLE;
                cmd_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_50) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            op_q         <= 3'd0;
            x_q          <= 9'd0;
            row_q        <= 9'd0;
            lat_q        <= '0;
            cmd_ready_q  <= 1'b1;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            frame_we_q   <= 1'b0;
            frame_addr_q <= 9'd0;
            frame_din_q  <= '0;
            pic_we_q     <= 1'b0;
            pic_addr_q   <= 10'd0;
            pic_din_q    <= 26'd0;
            word_we_q    <= 1'b0;
            word_addr_q  <= 10'd0;
            word_din_q   <= 26'd0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            x_q          <= x_d;
            row_q        <= row_d;
            lat_q        <= lat_d;
            cmd_ready_q  <= cmd_ready_d;
            done_q       <= done_d;
            err_q        <= err_d;
            frame_we_q   <= frame_we_d;
            frame_addr_q <= frame_addr_d;
            frame_din_q  <= frame_din_d;
            pic_we_q     <= pic_we_d;
            pic_addr_q   <= pic_addr_d;
            pic_din_q    <= pic_din_d;
            word_we_q    <= word_we_d;
            word_addr_q  <= word_addr_d;
            word_din_q   <= word_din_d;
        end
    end

    assign cmd_ready                       = cmd_ready_q;
    assign done                            = done_q;
    assign err                             = err_q;
    assign ram_480_480_write               = frame_we_q;
    assign ram_480_480_address_rw          = frame_addr_q;
    assign ram_480_480_din                 = frame_din_q;
    assign ram_picture_position_write      = pic_we_q;
    assign ram_picture_position_address_rw = pic_addr_q;
    assign ram_picture_position_din        = pic_din_q;
    assign ram_word_position_write         = word_we_q;
    assign ram_word_position_address_b     = word_addr_q;
    assign ram_word_position_din           = word_din_q;

endmodule

// File: tb/tb_vga_frame_writer.sv
// tb/tb_vga_frame_writer.sv - randomized self-checking bench for vga_frame_writer
module tb_vga_frame_writer;

    logic         clk_50 = 1'b0;
    logic         rst_n;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [2:0]   cmd_op;
    logic [8:0]   cmd_x, cmd_y;
    logic [9:0]   cmd_idx;
    logic [25:0]  cmd_data;
    logic         done, err;
    logic         fw_we;
    logic [8:0]   fw_addr;
    logic [479:0] fw_din, fw_dout;
    logic         pic_we, word_we;
    logic [9:0]   pic_addr, word_addr;
    logic [25:0]  pic_din, word_din;

    always #10 clk_50 = ~clk_50;

    vga_frame_writer dut (
        .clk_50(clk_50), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_idx(cmd_idx), .cmd_data(cmd_data),
        .done(done), .err(err),
        .ram_480_480_write(fw_we), .ram_480_480_address_rw(fw_addr),
        .ram_480_480_din(fw_din), .ram_480_480_dout_rw(fw_dout),
        .ram_picture_position_write(pic_we), .ram_picture_position_address_rw(pic_addr),
        .ram_picture_position_din(pic_din),
        .ram_word_position_write(word_we), .ram_word_position_address_b(word_addr),
        .ram_word_position_din(word_din)
    );

`ifdef VGA_WR_XOR_EN
    localparam bit XOR_EN = 1'b1;
`else
    localparam bit XOR_EN = 1'b0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [479:0] got, input logic [479:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Frame RAM port B with one clock of read latency; ref_mem is the expected image.
    logic [479:0] fmem    [480];
    logic [479:0] ref_mem [480];

    always @(posedge clk_50) begin
        if (fw_we) fmem[fw_addr] <= fw_din;
        fw_dout <= fmem[fw_addr];
    end

    int           fw_cnt, pic_cnt, word_cnt, multi_we, cls_exp;
    bit           cls_mon;
    logic [8:0]   fw_last_addr;
    logic [479:0] fw_last_din;
    logic [9:0]   pic_last_addr, word_last_addr;
    logic [25:0]  pic_last_din, word_last_din;

    always @(negedge clk_50) begin
        if (fw_we) begin
            fw_cnt++;
            fw_last_addr = fw_addr;
            fw_last_din  = fw_din;
            if (cls_mon) begin
                check("cls_addr", 480'(fw_addr), 480'(cls_exp));
                check("cls_din", fw_din, 480'd0);
                cls_exp++;
            end
        end
        if (pic_we)  begin pic_cnt++;  pic_last_addr  = pic_addr;  pic_last_din  = pic_din;  end
        if (word_we) begin word_cnt++; word_last_addr = word_addr; word_last_din = word_din; end
        if (int'(fw_we) + int'(pic_we) + int'(word_we) > 1) multi_we++;
    end

    task automatic run_cmd(input logic [2:0] op, input logic [8:0] x, input logic [8:0] y,
                           input logic [9:0] idx, input logic [25:0] data,
                           output int lat, output logic got_err, output int ready_hi);
        int n;
        @(negedge clk_50);
        n = 0;
        while (!cmd_ready && n < 1000) begin @(negedge clk_50); n++; end
        if (!cmd_ready) check("ready_timeout", 480'd0, 480'd1);
        fw_cnt = 0; pic_cnt = 0; word_cnt = 0; multi_we = 0;
        cmd_op = op; cmd_x = x; cmd_y = y; cmd_idx = idx; cmd_data = data;
        cmd_valid = 1'b1;
        @(posedge clk_50);
        #1 cmd_valid = 1'b0;
        lat = 0; got_err = 1'b0; ready_hi = 0;
        while (lat < 2000) begin
            @(negedge clk_50);
            lat++;
            if (cmd_ready) ready_hi++;
            if (done) begin got_err = err; break; end
        end
        if (!done) check("done_timeout", 480'd0, 480'd1);
        @(negedge clk_50);
        check("done_pulse", 480'(done), 480'd0);
        check("ready_back", 480'(cmd_ready), 480'd1);
    endtask

    task automatic exec(input logic [2:0] op, input logic [8:0] x, input logic [8:0] y,
                        input logic [9:0] idx, input logic [25:0] data);
        bit   pix, ok_pix, exp_err;
        int   exp_lat, exp_fw, lat, ready_hi;
        logic got_err;
        pix     = (op == 3'd0) || (op == 3'd1) || ((op == 3'd2) && XOR_EN);
        ok_pix  = pix && (x < 9'd480) && (y < 9'd480);
        exp_err = (pix && !ok_pix) || (op >= 3'd6) || ((op == 3'd2) && !XOR_EN);
        exp_lat = exp_err ? 1 : (op == 3'd3) ? 482 : (op >= 3'd4) ? 2 : 4;
        exp_fw  = ok_pix ? 1 : (op == 3'd3) ? 480 : 0;
        if (op == 3'd3) begin cls_mon = 1'b1; cls_exp = 0; end
        run_cmd(op, x, y, idx, data, lat, got_err, ready_hi);
        cls_mon = 1'b0;
        check("latency", 480'(lat), 480'(exp_lat));
        check("err", 480'(got_err), 480'(exp_err));
        check("frame_writes", 480'(fw_cnt), 480'(exp_fw));
        check("pic_writes", 480'(pic_cnt), 480'((op == 3'd4) ? 1 : 0));
        check("word_writes", 480'(word_cnt), 480'((op == 3'd5) ? 1 : 0));
        check("ready_busy", 480'(ready_hi), 480'd0);
        check("one_we", 480'(multi_we), 480'd0);
        if (ok_pix) begin
            case (op)
                3'd0:    ref_mem[y][x] = 1'b1;
                3'd1:    ref_mem[y][x] = 1'b0;
                default: ref_mem[y][x] = ~ref_mem[y][x];
            endcase
            check("pix_addr", 480'(fw_last_addr), 480'(y));
            check("pix_din", fw_last_din, ref_mem[y]);
            check("pix_row", fmem[y], ref_mem[y]);
        end
        if (op == 3'd3) begin
            for (int i = 0; i < 480; i++) ref_mem[i] = '0;
            check("cls_row0", fmem[0], 480'd0);
            check("cls_row479", fmem[479], 480'd0);
        end
        if (op == 3'd4) begin
            check("pic_addr", 480'(pic_last_addr), 480'(idx));
            check("pic_din", 480'(pic_last_din), 480'(data));
        end
        if (op == 3'd5) begin
            check("word_addr", 480'(word_last_addr), 480'(idx));
            check("word_din", 480'(word_last_din), 480'(data));
        end
    endtask

    function automatic logic [479:0] rand_row();
        logic [479:0] v;
        for (int k = 0; k < 15; k++) v[k*32 +: 32] = $urandom();
        return v;
    endfunction

    initial begin
        logic [479:0] orig;
        logic [2:0]   op;
        int           r, n;
        fw_cnt = 0; pic_cnt = 0; word_cnt = 0; multi_we = 0; cls_mon = 1'b0; cls_exp = 0;
        fw_last_addr = '0; fw_last_din = '0;
        pic_last_addr = '0; pic_last_din = '0; word_last_addr = '0; word_last_din = '0;
        for (int i = 0; i < 480; i++) begin fmem[i] <= '0; ref_mem[i] = '0; end
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_x = '0; cmd_y = '0;
        cmd_idx = '0; cmd_data = '0;
        repeat (3) @(negedge clk_50);
        check("rst_ready", 480'(cmd_ready), 480'd1);
        check("rst_done_err", 480'({done, err}), 480'd0);
        check("rst_we", 480'({fw_we, pic_we, word_we}), 480'd0);
        check("rst_addr", 480'({fw_addr, pic_addr, word_addr}), 480'd0);
        check("rst_din", fw_din | 480'({pic_din, word_din}), 480'd0);
        rst_n = 1'b1;

        exec(3'd0, 9'd0, 9'd0, 10'd0, 26'd0);
        @(negedge clk_50);
        fmem[5] <= '1; ref_mem[5] = '1;
        exec(3'd1, 9'd479, 9'd5, 10'd0, 26'd0);
        exec(3'd3, 9'd0, 9'd0, 10'd0, 26'd0);
        exec(3'd0, 9'd480, 9'd10, 10'd0, 26'd0);
        exec(3'd0, 9'd3, 9'd480, 10'd0, 26'd0);
        exec(3'd4, 9'd0, 9'd0, 10'd1023, 26'h3FF_FFFF);
        exec(3'd5, 9'd0, 9'd0, 10'd17, 26'h155_5555);
        exec(3'd7, 9'd1, 9'd1, 10'd0, 26'd0);

        @(negedge clk_50);
        for (int i = 0; i < 480; i++) begin
            orig = rand_row();
            fmem[i] <= orig; ref_mem[i] = orig;
        end
        @(negedge clk_50);
        orig = ref_mem[2];
        exec(3'd2, 9'd7, 9'd2, 10'd0, 26'd0);
        exec(3'd2, 9'd7, 9'd2, 10'd0, 26'd0);
        check("xor_twice", fmem[2], orig);

        for (int t = 0; t < 60; t++) begin
            r = $urandom_range(0, 9);
            op = (r < 3) ? 3'd0 : (r < 5) ? 3'd1 : (r < 7) ? 3'd2 :
                 (r == 7) ? 3'd4 : (r == 8) ? 3'd5 : 3'(6 + $urandom_range(0, 1));
            exec(op,
                 ($urandom_range(0, 7) == 0) ? 9'($urandom_range(480, 511)) : 9'($urandom_range(0, 479)),
                 ($urandom_range(0, 7) == 0) ? 9'($urandom_range(480, 511)) : 9'($urandom_range(0, 479)),
                 10'($urandom_range(0, 1023)), 26'($urandom()));
        end

        // Reset while CLS is writing row 100.
        @(negedge clk_50);
        cmd_op = 3'd3; cmd_valid = 1'b1; cls_mon = 1'b1; cls_exp = 0;
        @(posedge clk_50);
        #1 cmd_valid = 1'b0;
        n = 0;
        while (n < 1000) begin
            @(negedge clk_50);
            n++;
            if (fw_we && fw_addr == 9'd100) break;
        end
        check("cls_reach_100", 480'(fw_we && fw_addr == 9'd100), 480'd1);
        rst_n = 1'b0;
        @(negedge clk_50);
        check("rst_mid_we", 480'(fw_we), 480'd0);
        check("rst_mid_done", 480'(done), 480'd0);
        @(negedge clk_50);
        check("rst_mid_done2", 480'(done), 480'd0);
        rst_n = 1'b1;
        cls_mon = 1'b0;
        @(negedge clk_50);
        check("rst_mid_ready", 480'(cmd_ready), 480'd1);
        check("rst_mid_done3", 480'(done), 480'd0);
        for (int i = 0; i <= 100; i++) ref_mem[i] = '0;

        for (int i = 0; i < 480; i++) check("final_row", fmem[i], ref_mem[i]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
